// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants for the 3x3 systolic convolution front end:
//               default pixel width, image geometry and feeder state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Default pixel width in bits
    localparam int c_DATA_WIDTH    = 8;

    // The array produces OUTPUT_CYCLES valid windows per row; the two edge
    // windows that straddle a row boundary are absorbed by its per-row stall,
    // so the feeder row length is always two pixels longer.
    localparam int c_OUTPUT_CYCLES = 220;
    localparam int c_IMG_WIDTH     = c_OUTPUT_CYCLES + 2;
    localparam int c_IMG_HEIGHT    = 222;

    // Feeder state encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FILL   = 2'd1;
    localparam logic [1:0] c_ST_STREAM = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : conv_line_buffer
// Description : One image row of storage. 1R1W, combinational read,
//               registered write, so a read and write to the same address
//               in one cycle returns the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = c_IMG_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Contents need no reset: every location is rewritten before it is read
    // out as part of a column.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign rd_data = r_mem[rd_addr];

    // Write port; the read above still sees the pre-write value this cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_column_feeder.sv
`default_nettype none
// ============================================================================
// Module      : conv_column_feeder
// Description : Raster-to-column front end for the 3x3 systolic array.
//               Buffers the two previous rows and, from row 2 onward, emits
//               one vertical 3-pixel column per accepted pixel, one cycle
//               after acceptance. Also strobes load_weight at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_column_feeder
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int IMG_WIDTH  = c_IMG_WIDTH,
    parameter int IMG_HEIGHT = c_IMG_HEIGHT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   pix_in,
    input  logic                    pix_valid,
    input  logic                    pix_sof,
    output logic                    pix_ready,
    output logic                    col,
    output logic [3*DATA_WIDTH-1:0] input_col,
    output logic                    load_weight,
    output logic                    frame_done
);

    localparam int              c_XW          = $clog2(IMG_WIDTH);
    localparam int              c_YW          = $clog2(IMG_HEIGHT);
    localparam logic [c_XW-1:0] c_X_LAST      = c_XW'(IMG_WIDTH - 1);
    localparam logic [c_YW-1:0] c_Y_LAST      = c_YW'(IMG_HEIGHT - 1);
    localparam logic [c_YW-1:0] c_Y_FILL_LAST = c_YW'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_XW-1:0]       r_x;
    logic [c_XW-1:0]       w_x_nxt;
    logic [c_YW-1:0]       r_y;
    logic [c_YW-1:0]       w_y_nxt;

    logic                  w_accept;
    logic                  w_last_pix;
    logic                  w_restart;
    logic                  w_emit;
    logic                  w_frame_end;
    logic                  w_lb_we;
    logic [c_XW-1:0]       w_lb_addr;
    logic [DATA_WIDTH-1:0] w_lb0_rd;
    logic [DATA_WIDTH-1:0] w_lb1_rd;

    logic                    r_col;
    logic [3*DATA_WIDTH-1:0] r_input_col;
    logic                    r_load_weight;
    logic                    r_frame_done;

    // Ready is forced low while reset is held so nothing is taken mid-reset
    assign pix_ready  = (r_state != c_ST_DONE) && !rst;
    assign w_accept   = pix_valid && pix_ready;

    // Final pixel of the frame; a sof on this pixel must not abort the frame
    assign w_last_pix = (r_state == c_ST_STREAM) && (r_x == c_X_LAST) && (r_y == c_Y_LAST);

    // A restarting pixel is (0,0) of the new frame regardless of old x
    assign w_lb_addr  = w_restart ? '0 : r_x;

    // lb0 holds row y-1; lb1 receives lb0's old value so it holds row y-2
    conv_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_WIDTH (c_XW)
    ) u_lb0 (
        .clk     (clk),
        .wr_en   (w_lb_we),
        .wr_addr (w_lb_addr),
        .wr_data (pix_in),
        .rd_addr (w_lb_addr),
        .rd_data (w_lb0_rd)
    );

    conv_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_WIDTH (c_XW)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (w_lb_we),
        .wr_addr (w_lb_addr),
        .wr_data (w_lb0_rd),
        .rd_addr (w_lb_addr),
        .rd_data (w_lb1_rd)
    );

    // Next-state, counter and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_restart   = 1'b0;
        w_emit      = 1'b0;
        w_frame_end = 1'b0;
        w_lb_we     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // Pixels before a sof belong to no frame and are dropped
                if (w_accept && pix_sof) begin
                    w_restart   = 1'b1;
                    w_lb_we     = 1'b1;
                    w_state_nxt = c_ST_FILL;
                    w_x_nxt     = c_XW'(1);
                    w_y_nxt     = '0;
                end
            end
            c_ST_FILL, c_ST_STREAM: begin
                if (w_accept) begin
                    w_lb_we = 1'b1;
                    if (pix_sof && !w_last_pix) begin
                        // Abandon the current frame; rows 0 and 1 of the new
                        // frame overwrite all stale line data before STREAM
                        w_restart   = 1'b1;
                        w_state_nxt = c_ST_FILL;
                        w_x_nxt     = c_XW'(1);
                        w_y_nxt     = '0;
                    end else begin
                        w_emit = (r_state == c_ST_STREAM);
                        if (r_x == c_X_LAST) begin
                            w_x_nxt = '0;
                            if (w_last_pix) begin
                                w_frame_end = 1'b1;
                                w_state_nxt = c_ST_DONE;
                                w_y_nxt     = '0;
                            end else begin
                                w_y_nxt = r_y + c_YW'(1);
                                if ((r_state == c_ST_FILL) && (r_y == c_Y_FILL_LAST)) begin
                                    w_state_nxt = c_ST_STREAM;
                                end
                            end
                        end else begin
                            w_x_nxt = r_x + c_XW'(1);
                        end
                    end
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State and raster position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    // Output registers: one cycle from accept to column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col         <= 1'b0;
            r_input_col   <= '0;
            r_load_weight <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_col         <= w_emit;
            r_load_weight <= w_restart;
            r_frame_done  <= w_frame_end;
            if (w_emit) begin
                r_input_col <= {w_lb1_rd, w_lb0_rd, pix_in};
            end
        end
    end

    assign col         = r_col;
    assign input_col   = r_input_col;
    assign load_weight = r_load_weight;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_column_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_column_feeder
// Description : Directed self-checking bench for conv_column_feeder on a
//               4x4 image, pixel value = base + 16*y + x.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_column_feeder;

    localparam int c_W  = 4;
    localparam int c_H  = 4;
    localparam int c_DW = 8;

    logic            clk;
    logic            rst;
    logic [c_DW-1:0] pix_in;
    logic            pix_valid;
    logic            pix_sof;
    logic            pix_ready;
    logic            col;
    logic [3*c_DW-1:0] input_col;
    logic            load_weight;
    logic            frame_done;

    int n_checks;
    int n_fail;
    int cyc;

    int          acc_q[$];
    logic [23:0] col_q[$];
    int          colcyc_q[$];
    int          fd_q[$];
    int          lw_q[$];

    conv_column_feeder #(
        .DATA_WIDTH (c_DW),
        .IMG_WIDTH  (c_W),
        .IMG_HEIGHT (c_H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .pix_sof     (pix_sof),
        .pix_ready   (pix_ready),
        .col         (col),
        .input_col   (input_col),
        .load_weight (load_weight),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: acceptance sampled just before each rising edge, outputs 1 after
    initial begin
        logic acc;
        cyc = 0;
        forever begin
            @(negedge clk);
            #4;
            acc = pix_valid && pix_ready;
            @(posedge clk);
            cyc++;
            if (acc) acc_q.push_back(cyc);
            #1;
            if (col) begin
                col_q.push_back(input_col);
                colcyc_q.push_back(cyc);
            end
            if (frame_done) fd_q.push_back(cyc);
            if (load_weight) lw_q.push_back(cyc);
        end
    end

    function automatic logic [23:0] exp_col(input logic [7:0] base, input int k);
        logic [7:0] bot;
        bot = base + 8'(16 * (2 + k / 4) + k % 4);
        return {bot - 8'h20, bot - 8'h10, bot};
    endfunction

    task automatic clear_q();
        acc_q.delete(); col_q.delete(); colcyc_q.delete(); fd_q.delete(); lw_q.delete();
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; holds the pixel until accepted, returns at a falling edge
    task automatic drive(input logic [7:0] v, input logic sof, output int waits);
        logic ok;
        logic rdy;
        ok = 1'b0;
        waits = 0;
        pix_in = v; pix_sof = sof; pix_valid = 1'b1;
        while (!ok && waits < 20) begin
            #4;
            rdy = pix_ready;
            @(posedge clk);
            waits++;
            if (rdy) ok = 1'b1;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL drive_timeout: pixel %h not accepted, ready=%b required 1", v, pix_ready);
        end
    endtask

    task automatic send_frame(input logic gaps, input logic [7:0] base, input int npix,
                              output int first_waits);
        int w;
        first_waits = 0;
        for (int i = 0; i < npix; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 2));
            drive(base + 8'(16 * (i / 4) + i % 4), (i == 0), w);
            if (i == 0) first_waits = w;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({col, load_weight, frame_done, pix_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: col/lw/fd/ready=%b required 0000", {col, load_weight, frame_done, pix_ready});
        end
        n_checks++;
        if (input_col !== 24'h0) begin
            n_fail++; $display("FAIL reset_input_col: got %h required 000000", input_col);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pix_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_ready: got %b required 1", pix_ready);
        end
    endtask

    task automatic test_full_frame();
        int w;
        clear_q();
        send_frame(1'b0, 8'h00, 16, w);
        idle(4);
        n_checks++;
        if (lw_q.size() != 1 || acc_q.size() != 16) begin
            n_fail++; $display("FAIL full_lw_count: lw=%0d acc=%0d required 1 and 16", lw_q.size(), acc_q.size());
        end else begin
            n_checks++;
            if (lw_q[0] != acc_q[0]) begin
                n_fail++; $display("FAIL full_lw_timing: lw cycle %0d required %0d", lw_q[0], acc_q[0]);
            end
        end
        n_checks++;
        if (col_q.size() != 8) begin
            n_fail++; $display("FAIL full_col_count: got %0d required 8", col_q.size());
        end else begin
            n_checks++;
            if (col_q[0] !== 24'h001020) begin
                n_fail++; $display("FAIL full_first_col: got %h required 001020", col_q[0]);
            end
            n_checks++;
            if (col_q[7] !== 24'h132333) begin
                n_fail++; $display("FAIL full_last_col: got %h required 132333", col_q[7]);
            end
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (col_q[k] !== exp_col(8'h00, k) || colcyc_q[k] != acc_q[8 + k]) begin
                    n_fail++;
                    $display("FAIL full_col[%0d]: got %h @%0d required %h @%0d", k, col_q[k], colcyc_q[k], exp_col(8'h00, k), acc_q[8 + k]);
                end
            end
            n_checks++;
            if (fd_q.size() != 1 || fd_q[0] != colcyc_q[7]) begin
                n_fail++; $display("FAIL full_frame_done: count %0d required 1 at cycle %0d", fd_q.size(), colcyc_q[7]);
            end
        end
    endtask

    task automatic test_gaps();
        int w;
        clear_q();
        send_frame(1'b1, 8'h00, 16, w);
        idle(4);
        n_checks++;
        if (col_q.size() != 8 || acc_q.size() != 16) begin
            n_fail++; $display("FAIL gap_col_count: cols %0d acc %0d required 8 and 16", col_q.size(), acc_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (col_q[k] !== exp_col(8'h00, k) || colcyc_q[k] != acc_q[8 + k]) begin
                    n_fail++;
                    $display("FAIL gap_col[%0d]: got %h @%0d required %h @%0d", k, col_q[k], colcyc_q[k], exp_col(8'h00, k), acc_q[8 + k]);
                end
            end
            n_checks++;
            if (fd_q.size() != 1 || fd_q[0] != colcyc_q[7]) begin
                n_fail++; $display("FAIL gap_frame_done: count %0d required 1", fd_q.size());
            end
        end
    endtask

    task automatic test_no_sof();
        int w;
        clear_q();
        for (int i = 0; i < 6; i++) drive(8'hE0 + 8'(i), 1'b0, w);
        idle(3);
        n_checks++;
        if (acc_q.size() != 6 || col_q.size() != 0 || lw_q.size() != 0) begin
            n_fail++; $display("FAIL nosof_discard: acc %0d col %0d lw %0d required 6 0 0", acc_q.size(), col_q.size(), lw_q.size());
        end
        send_frame(1'b0, 8'h00, 16, w);
        idle(4);
        n_checks++;
        if (col_q.size() != 8 || lw_q.size() != 1 || fd_q.size() != 1) begin
            n_fail++; $display("FAIL nosof_frame: col %0d lw %0d fd %0d required 8 1 1", col_q.size(), lw_q.size(), fd_q.size());
        end else begin
            n_checks++;
            if (col_q[0] !== 24'h001020) begin
                n_fail++; $display("FAIL nosof_first_col: got %h required 001020", col_q[0]);
            end
        end
    endtask

    task automatic test_sof_restart();
        int w;
        clear_q();
        send_frame(1'b0, 8'h00, 10, w);
        send_frame(1'b0, 8'h80, 16, w);
        idle(4);
        n_checks++;
        if (lw_q.size() != 2 || fd_q.size() != 1) begin
            n_fail++; $display("FAIL restart_strobes: lw %0d fd %0d required 2 1", lw_q.size(), fd_q.size());
        end
        n_checks++;
        if (col_q.size() != 10) begin
            n_fail++; $display("FAIL restart_col_count: got %0d required 10", col_q.size());
        end else begin
            n_checks++;
            if (col_q[1] !== 24'h011121) begin
                n_fail++; $display("FAIL restart_old_col: got %h required 011121", col_q[1]);
            end
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (col_q[2 + k] !== exp_col(8'h80, k)) begin
                    n_fail++; $display("FAIL restart_new_col[%0d]: got %h required %h", k, col_q[2 + k], exp_col(8'h80, k));
                end
            end
            n_checks++;
            if (fd_q.size() != 1 || fd_q[0] != colcyc_q[9]) begin
                n_fail++; $display("FAIL restart_frame_done: count %0d required 1 on last col", fd_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        clear_q();
        send_frame(1'b0, 8'h00, 10, w);
        n_checks++;
        if (col !== 1'b1 || input_col !== 24'h011121) begin
            n_fail++; $display("FAIL midrst_pre: col %b data %h required 1 011121", col, input_col);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({col, load_weight, frame_done, pix_ready} !== 4'b0000 || input_col !== 24'h0) begin
            n_fail++; $display("FAIL midrst_async: col/lw/fd/ready=%b data %h required 0000 000000", {col, load_weight, frame_done, pix_ready}, input_col);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_q();
        send_frame(1'b0, 8'h00, 16, w);
        idle(4);
        n_checks++;
        if (col_q.size() != 8 || fd_q.size() != 1 || lw_q.size() != 1) begin
            n_fail++; $display("FAIL midrst_frame: col %0d fd %0d lw %0d required 8 1 1", col_q.size(), fd_q.size(), lw_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (col_q[k] !== exp_col(8'h00, k)) begin
                    n_fail++; $display("FAIL midrst_col[%0d]: got %h required %h", k, col_q[k], exp_col(8'h00, k));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int w;
        clear_q();
        send_frame(1'b0, 8'h00, 16, w);
        send_frame(1'b0, 8'h40, 16, w);
        idle(4);
        n_checks++;
        if (w != 2) begin
            n_fail++; $display("FAIL b2b_sof_wait: sof took %0d cycles required 2", w);
        end
        n_checks++;
        if (fd_q.size() != 2 || col_q.size() != 16 || lw_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_counts: fd %0d col %0d lw %0d required 2 16 2", fd_q.size(), col_q.size(), lw_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (col_q[8 + k] !== exp_col(8'h40, k)) begin
                    n_fail++; $display("FAIL b2b_col[%0d]: got %h required %h", k, col_q[8 + k], exp_col(8'h40, k));
                end
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_in    = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_full_frame();
        test_gaps();
        test_no_sof();
        test_sof_restart();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t required < 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
